// File: rtl/load_store_unit.sv
// Byte-addressed load/store front end for a word RAM with async read: big-endian lanes,
// sign/zero extension, alignment checks, sub-word RMW. Define LSU_RANGE_CHECK_EN to reject high address bits.
module load_store_unit #(
  parameter int MEM_AW = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [1:0]        req_size,
  input  logic              req_signed,
  input  logic [31:0]       req_addr,
  input  logic [31:0]       req_wdata,
  output logic              rsp_valid,
  output logic [31:0]       rsp_rdata,
  output logic              rsp_err,
  output logic [MEM_AW-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic              mem_we,
  input  logic [31:0]       mem_rdata
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RD,
    S_WR,
    S_RSP
  } state_t;

  state_t            r_state;
  logic              r_we;
  logic [1:0]        r_size;
  logic              r_signed;
  logic [1:0]        r_off;
  logic [15:0]       r_wdata;
  logic [MEM_AW-1:0] r_mem_addr;
  logic [31:0]       r_mem_wdata;
  logic              r_mem_we;
  logic              r_rsp_valid;
  logic              r_rsp_err;
  logic [31:0]       r_rsp_rdata;

  logic              w_illegal;
  logic [4:0]        w_bsh;
  logic [4:0]        w_hsh;
  logic [7:0]        w_byte;
  logic [15:0]       w_half;
  logic [31:0]       w_load;
  logic [31:0]       w_mask;
  logic [31:0]       w_lane;
  logic [31:0]       w_merged;

`ifdef LSU_RANGE_CHECK_EN
  always_comb begin
    w_illegal = (req_size == 2'b11)
             || ((req_size == 2'b01) && req_addr[0])
             || ((req_size == 2'b10) && (req_addr[1:0] != 2'b00))
             || (req_addr[31:MEM_AW+2] != '0);
  end
`else
  logic w_unused_hi;
  assign w_unused_hi = |req_addr[31:MEM_AW+2];

  always_comb begin
    w_illegal = (req_size == 2'b11)
             || ((req_size == 2'b01) && req_addr[0])
             || ((req_size == 2'b10) && (req_addr[1:0] != 2'b00));
  end
`endif

  // Big-endian: lane at offset k sits (3-k) bytes above bit 0, and 3-k == ~k for 2 bits.
  always_comb begin
    w_bsh  = {~r_off, 3'b000};
    w_hsh  = {~r_off[1], 4'b0000};
    w_byte = 8'(mem_rdata >> w_bsh);
    w_half = 16'(mem_rdata >> w_hsh);
    case (r_size)
      2'b00:   w_load = r_signed ? {{24{w_byte[7]}}, w_byte} : {24'h000000, w_byte};
      2'b01:   w_load = r_signed ? {{16{w_half[15]}}, w_half} : {16'h0000, w_half};
      default: w_load = mem_rdata;
    endcase
    if (r_size == 2'b00) begin
      w_mask = 32'h000000FF << w_bsh;
      w_lane = {4{r_wdata[7:0]}};
    end else begin
      w_mask = 32'h0000FFFF << w_hsh;
      w_lane = {2{r_wdata}};
    end
    w_merged = (mem_rdata & ~w_mask) | (w_lane & w_mask);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_we        <= 1'b0;
      r_size      <= 2'b00;
      r_signed    <= 1'b0;
      r_off       <= 2'b00;
      r_wdata     <= '0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_mem_we    <= 1'b0;
      r_rsp_valid <= 1'b0;
      r_rsp_err   <= 1'b0;
      r_rsp_rdata <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_rsp_valid <= 1'b0;
          r_rsp_err   <= 1'b0;
          if (req_valid) begin
            r_we        <= req_we;
            r_size      <= req_size;
            r_signed    <= req_signed;
            r_off       <= req_addr[1:0];
            r_wdata     <= req_wdata[15:0];
            r_mem_addr  <= req_addr[MEM_AW+1:2];
            r_rsp_rdata <= '0;
            if (w_illegal) begin
              r_rsp_valid <= 1'b1;
              r_rsp_err   <= 1'b1;
              r_state     <= S_RSP;
            end else if (req_we && (req_size == 2'b10)) begin
              r_mem_wdata <= req_wdata;
              r_mem_we    <= 1'b1;
              r_state     <= S_WR;
            end else begin
              r_state     <= S_RD;
            end
          end
        end
        // Sub-word stores merge the old word here so WR only has to strobe mem_we.
        S_RD: begin
          if (r_we) begin
            r_mem_wdata <= w_merged;
            r_mem_we    <= 1'b1;
            r_state     <= S_WR;
          end else begin
            r_rsp_rdata <= w_load;
            r_rsp_valid <= 1'b1;
            r_state     <= S_RSP;
          end
        end
        S_WR: begin
          r_mem_we    <= 1'b0;
          r_rsp_valid <= 1'b1;
          r_state     <= S_RSP;
        end
        S_RSP: begin
          r_rsp_valid <= 1'b0;
          r_rsp_err   <= 1'b0;
          r_state     <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Outputs are gated so they read as idle while reset is held, even in its first cycle.
  assign req_ready = (r_state == S_IDLE) && !reset;
  assign mem_we    = r_mem_we && !reset;
  assign rsp_valid = r_rsp_valid && !reset;
  assign rsp_err   = r_rsp_err && !reset;
  assign rsp_rdata = reset ? '0 : r_rsp_rdata;
  assign mem_addr  = reset ? '0 : r_mem_addr;
  assign mem_wdata = reset ? '0 : r_mem_wdata;

endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
- Sits between the CPU execute/memory stage and the word-organised data RAM, which has an asynchronous read port and a write port sampled on the clock edge.
- Converts byte-addressed LB/LBU/LH/LHU/LW/SB/SH/SW requests into word accesses, including big-endian lane selection, sign/zero extension, alignment checking, and read-modify-write for sub-word stores.
- Presents a valid/ready request port and a one-cycle response pulse so the CPU control can stall.

Parameters:
MEM_AW, 8, word-address width driven to the RAM; the RAM holds 2^MEM_AW 32-bit words.

Ports:
clk  input  1  system clock, rising edge
reset  input  1  synchronous, active-high reset
req_valid  input  1  request present
req_ready  output  1  block can accept a request
req_we  input  1  1 = store, 0 = load
req_size  input  2  00 byte, 01 half, 10 word, 11 reserved
req_signed  input  1  loads only: 1 = sign-extend, 0 = zero-extend
req_addr  input  32  byte address
req_wdata  input  32  store data, right-justified
rsp_valid  output  1  one-cycle completion pulse
rsp_rdata  output  32  load result, extended
rsp_err  output  1  misaligned/illegal request, qualified by rsp_valid
mem_addr  output  MEM_AW  word address, = req_addr[MEM_AW+1:2]
mem_wdata  output  32  merged write word
mem_we  output  1  RAM write enable
mem_rdata  input  32  RAM asynchronous read data

Behaviour:
- Reset: the FSM is held in IDLE and all outputs are driven as follows.
  - rsp_valid=0, rsp_err=0, rsp_rdata=0, mem_addr=0, mem_wdata=0, mem_we=0.
  - req_ready=0 while reset is high.
- Request latching: req_ready=1 only in IDLE with reset low. Accept occurs on req_valid&&req_ready. On accept the block registers addr, size, signed, we, wdata, and byte offset addr[1:0].
- States: IDLE, RD, WR, RSP.
  - IDLE -> RSP if the request is illegal; the memory is never touched.
  - IDLE -> RD for a load or a sub-word store.
  - IDLE -> WR for a word store.
  - RD -> RSP for a load. RD -> WR for a store.
  - WR -> RSP.
  - RSP -> IDLE unconditionally.
- Illegal requests:
  - size=11.
  - half with addr[0]=1.
  - word with addr[1:0]!=0.
- RD state: mem_addr is valid. Load: extract and extend the selected lane into the response register. Store: capture mem_rdata as the old word.
- WR state: mem_we=1 for exactly one cycle. mem_we is forced to 0 whenever reset=1.
- Lane mapping (big-endian):
  - Byte offset 0 -> bits 31:24, 1 -> 23:16, 2 -> 15:8, 3 -> 7:0.
  - Half offset 0 -> 31:16, offset 2 -> 15:0.
  - Store data comes from req_wdata[7:0] (byte) or req_wdata[15:0] (half), replicated into the selected lane; unselected lanes keep the old word.
- RSP state:
  - rsp_valid=1 for one cycle.
  - rsp_rdata holds the load value; it is 0 for stores and errors.
  - rsp_err=1 only for illegal requests.
  - req_ready=0.
- Latency (accept in cycle N, rsp_valid in the cycle shown):
  - Error: N+1.
  - Load: N+2.
  - Word store: N+2.
  - Sub-word store: N+3.
- A new request is accepted no earlier than the cycle after RSP.
- req_valid while busy is ignored; the CPU must hold it until ready.
- Reset mid-operation aborts with no write and no rsp_valid, including reset asserted in RD or WR.
- Outside range-check mode, req_addr bits above MEM_AW+1 are ignored (address aliasing).

Optional Feature:
- Macro LSU_RANGE_CHECK_EN.
- Defined: a request with req_addr[31:MEM_AW+2]!=0 is illegal. It takes the error path (rsp_err=1 at N+1, no memory access).
- Undefined: high address bits are discarded and the access wraps into the RAM.

Test Plan:
1. Preload word 1 = 0x8899AABB. LW addr 0x4 -> rsp_valid at N+2, rsp_rdata=0x8899AABB, rsp_err=0, mem_we never high.
2. LB signed addr 0x5 -> 0xFFFFFF99; LBU addr 0x5 -> 0x00000099; LH signed addr 0x6 -> 0xFFFFAABB; LHU addr 0x4 -> 0x00008899.
3. SB addr 0x6 wdata 0x12345677 -> single mem_we pulse at N+2 with mem_addr=1, mem_wdata=0x889977BB; rsp_valid at N+3; a subsequent LW 0x4 returns 0x889977BB.
4. LH addr 0x5, then SW addr 0x2, then size=11 -> each gives rsp_err=1 at N+1 with rsp_rdata=0; no mem_we; memory unchanged.
5. SH addr 0x4 wdata 0xCAFE, reset asserted in the RD cycle (N+1) -> no mem_we; no rsp_valid; req_ready=1 the cycle after reset drops; word 1 unchanged.
6. LW addr 0x400 with MEM_AW=8:
   - With LSU_RANGE_CHECK_EN: rsp_err=1 at N+1.
   - Without it: returns the content of word 0 at N+2.
